snake_game_ctrl: RTL and testbench

//  Game sequencer for the snake datapath. Generates the move-rate `update` pulse and the `start` level,
//  and owns the snake length `size`. It accumulates per-pixel collision flags from the renderer over each

---
 rtl/snake_game_ctrl.sv | 167 ++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move-rate strobe, start level, size/score, frame-end collision decisions.
// Optional build macro SNAKE_SPEEDUP_EN shortens the move period as the snake grows.
module snake_game_ctrl #(
    parameter int unsigned TICK_DIV   = 2500000,
    parameter int unsigned INIT_SIZE  = 3,
    parameter int unsigned MAX_SIZE   = 31,
    parameter int unsigned SPEED_STEP = 62500,
    parameter int unsigned MIN_DIV    = 500000
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       frame_end,
    input  logic       hit_apple,
    input  logic       hit_body,
    input  logic       hit_wall,
    output logic       update,
    output logic       start,
    output logic [4:0] size,
    output logic [7:0] score,
    output logic       apple_respawn,
    output logic       game_over
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DEAD = 2'd2;

    localparam logic [4:0] INIT_SIZE_L = 5'(INIT_SIZE);
    localparam logic [4:0] MAX_SIZE_L  = 5'(MAX_SIZE);

    // Reject parameter sets the datapath cannot represent (including a step whose
    // 31-segment reduction would overflow the 32-bit period arithmetic).
    if (TICK_DIV < 2 || MIN_DIV < 2 || INIT_SIZE < 1 || INIT_SIZE > MAX_SIZE ||
        MAX_SIZE > 31 || SPEED_STEP > 32'd138547332) begin : g_bad_params
        $error("snake_game_ctrl: illegal parameter set");
    end

    logic [1:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ate_q, ate_d;
    logic        kill_q, kill_d;
    logic        btn_q, btn_d;
    logic [4:0]  size_q, size_d;
    logic [7:0]  score_q, score_d;
    logic        update_q, update_d;
    logic        start_q, start_d;
    logic        respawn_q, respawn_d;
    logic        game_over_q, game_over_d;
    logic        btn_edge;
    logic [31:0] period;

`ifdef SNAKE_SPEEDUP_EN
    logic [31:0] reduction;

    // size_q never drops below INIT_SIZE while the period matters, so the difference is non-negative.
    always_comb begin
        reduction = 32'(size_q - INIT_SIZE_L) * 32'(SPEED_STEP);
        if (reduction + 32'(MIN_DIV) >= 32'(TICK_DIV)) begin
            period = 32'(MIN_DIV);
        end else begin
            period = 32'(TICK_DIV) - reduction;
        end
    end
`else
    assign period = 32'(TICK_DIV);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ate_d     = ate_q;
        kill_d    = kill_q;
        size_d    = size_q;
        score_d   = score_q;
        update_d  = 1'b0;
        respawn_d = 1'b0;
        btn_d     = btn_start;
        btn_edge  = btn_start & ~btn_q;

        case (state_q)
            S_IDLE: begin
                if (btn_edge) begin
                    state_d = S_RUN;
                    size_d  = INIT_SIZE_L;
                    score_d = 8'd0;
                    cnt_d   = 32'd0;
                    ate_d   = 1'b0;
                    kill_d  = 1'b0;
                end
            end
            S_RUN: begin
                // >= rather than == so a period that shrinks mid-count fires at once.
                if (cnt_q >= period - 32'd1) begin
                    update_d = 1'b1;
                    cnt_d    = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (frame_end) begin
                    if (kill_q) begin
                        state_d = S_DEAD;
                        cnt_d   = 32'd0;
                    end else if (ate_q) begin
                        size_d    = (size_q >= MAX_SIZE_L) ? MAX_SIZE_L : size_q + 5'd1;
                        score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        respawn_d = 1'b1;
                    end
                    // Hits seen during the frame_end cycle belong to the next frame.
                    ate_d  = hit_apple;
                    kill_d = hit_body | hit_wall;
                end else begin
                    ate_d  = ate_q | hit_apple;
                    kill_d = kill_q | hit_body | hit_wall;
                end
            end
            S_DEAD: begin
                cnt_d = 32'd0;
                if (btn_edge) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_d     = (state_d != S_IDLE);
        game_over_d = (state_d == S_DEAD);
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            ate_q       <= 1'b0;
            kill_q      <= 1'b0;
            btn_q       <= 1'b0;
            size_q      <= INIT_SIZE_L;
            score_q     <= 8'd0;
            update_q    <= 1'b0;
            start_q     <= 1'b0;
            respawn_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ate_q       <= ate_d;
            kill_q      <= kill_d;
            btn_q       <= btn_d;
            size_q      <= size_d;
            score_q     <= score_d;
            update_q    <= update_d;
            start_q     <= start_d;
            respawn_q   <= respawn_d;
            game_over_q <= game_over_d;
        end
    end

    assign update        = update_q;
    assign start         = start_q;
    assign size          = size_q;
    assign score         = score_q;
    assign apple_respawn = respawn_q;
    assign game_over     = game_over_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboarded bench for snake_game_ctrl; a behavioural game model queues the expected
// outputs for every driven cycle, plus directed checks of the spec scenarios.
module tb_snake_game_ctrl;

`ifdef SNAKE_SPEEDUP_EN
    localparam int TDIV = 40;
    localparam int STEP = 4;
    localparam int MIND = 8;
`else
    localparam int TDIV = 4;
    localparam int STEP = 1;
    localparam int MIND = 2;
`endif
    localparam int INIT = 3;
    localparam int MAXS = 31;

    logic       clk = 1'b0;
    logic       rst, btn, fe, ha, hb, hw;
    logic       update, start, apple_respawn, game_over;
    logic [4:0] size;
    logic [7:0] score;

    always #5 clk = ~clk;

    snake_game_ctrl #(
        .TICK_DIV(TDIV), .INIT_SIZE(INIT), .MAX_SIZE(MAXS),
        .SPEED_STEP(STEP), .MIN_DIV(MIND)
    ) dut (
        .VGA_clk(clk), .reset(rst), .btn_start(btn), .frame_end(fe),
        .hit_apple(ha), .hit_body(hb), .hit_wall(hw),
        .update(update), .start(start), .size(size), .score(score),
        .apple_respawn(apple_respawn), .game_over(game_over)
    );

    typedef struct {
        logic       upd;
        logic       st;
        logic [4:0] sz;
        logic [7:0] sc;
        logic       resp;
        logic       go;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Game model: 0 idle, 1 running, 2 dead.
    int m_state, m_cnt, m_size, m_score;
    bit m_ate, m_kill, m_btn;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model_period(input int sz);
        int p;
        p = TDIV;
`ifdef SNAKE_SPEEDUP_EN
        p = TDIV - (sz - INIT) * STEP;
        if (p < MIND) p = MIND;
`endif
        return p;
    endfunction

    task automatic model_step(input bit r, input bit b, input bit f, input bit a, input bit bd, input bit w);
        exp_t e;
        bit   pressed;
        int   per;
        e.upd  = 1'b0;
        e.resp = 1'b0;
        if (r) begin
            m_state = 0; m_cnt = 0; m_ate = 0; m_kill = 0; m_btn = 0;
            m_size = INIT; m_score = 0;
        end else begin
            pressed = b && !m_btn;
            m_btn   = b;
            if (m_state == 0) begin
                if (pressed) begin
                    m_state = 1; m_size = INIT; m_score = 0; m_cnt = 0; m_ate = 0; m_kill = 0;
                end
            end else if (m_state == 1) begin
                per = model_period(m_size);
                m_cnt++;
                if (m_cnt >= per) begin
                    e.upd = 1'b1;
                    m_cnt = 0;
                end
                if (f) begin
                    if (m_kill) begin
                        m_state = 2;
                        m_cnt   = 0;
                    end else if (m_ate) begin
                        if (m_size < MAXS) m_size++;
                        if (m_score < 255) m_score++;
                        e.resp = 1'b1;
                    end
                    m_ate  = a;
                    m_kill = bd || w;
                end else begin
                    m_ate  = m_ate || a;
                    m_kill = m_kill || bd || w;
                end
            end else begin
                m_cnt = 0;
                if (pressed) m_state = 0;
            end
        end
        e.st = (m_state != 0);
        e.go = (m_state == 2);
        e.sz = m_size[4:0];
        e.sc = m_score[7:0];
        sb_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic tick(input bit r, input bit b, input bit f, input bit a, input bit bd, input bit w);
        exp_t e;
        rst = r; btn = b; fe = f; ha = a; hb = bd; hw = w;
        model_step(r, b, f, a, bd, w);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val("sb_update",  update,        e.upd);
        check_val("sb_start",   start,         e.st);
        check_val("sb_size",    size,          e.sz);
        check_val("sb_score",   score,         e.sc);
        check_val("sb_respawn", apple_respawn, e.resp);
        check_val("sb_over",    game_over,     e.go);
    endtask

    task automatic apple_frame();
        tick(0, 1, 0, 1, 0, 0);
        tick(0, 1, 1, 0, 0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_update"},  update,        0);
        check_val({tag, "_start"},   start,         0);
        check_val({tag, "_size"},    size,          3);
        check_val({tag, "_score"},   score,         0);
        check_val({tag, "_respawn"}, apple_respawn, 0);
        check_val({tag, "_over"},    game_over,     0);
    endtask

`ifdef SNAKE_SPEEDUP_EN
    task automatic measure_period(input string tag, input int exp_p);
        int  n;
        bit  seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick(0, 1, 0, 0, 0, 0);
            seen = update;
        end
        n = 0;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick(0, 1, 0, 0, 0, 0);
            n++;
            seen = update;
        end
        check_val(tag, n, exp_p);
    endtask
`endif

    initial begin
        rst = 1; btn = 0; fe = 0; ha = 0; hb = 0; hw = 0;

        $display("txn: reset");
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        check_reset_values("rst");
        tick(0, 0, 0, 0, 0, 0);
        check_val("idle_start", start, 0);

        $display("txn: start game and update cadence");
        tick(0, 1, 0, 0, 0, 0);
        check_val("t1_start", start, 1);
        check_val("t1_size",  size,  3);
        for (int k = 1; k <= 3 * TDIV; k++) begin
            tick(0, 1, 0, 0, 0, 0);
            check_val($sformatf("t1_upd_c%0d", k), update, (k % TDIV == 0) ? 1 : 0);
        end

        $display("txn: apple eaten");
        tick(0, 1, 0, 1, 0, 0);
        tick(0, 1, 1, 0, 0, 0);
        check_val("t2_size",    size,          4);
        check_val("t2_score",   score,         1);
        check_val("t2_respawn", apple_respawn, 1);
        tick(0, 1, 0, 0, 0, 0);
        check_val("t2_respawn_end", apple_respawn, 0);
        tick(0, 1, 1, 0, 0, 0);
        check_val("t2_nohit_size", size, 4);
        check_val("t2_nohit_resp", apple_respawn, 0);
        tick(0, 1, 1, 1, 0, 0);
        check_val("t2_seed_size", size, 4);
        tick(0, 1, 1, 0, 0, 0);
        check_val("t2_seeded_size",  size,  5);
        check_val("t2_seeded_score", score, 2);

        $display("txn: death beats apple");
        tick(0, 1, 0, 1, 0, 1);
        tick(0, 1, 1, 0, 0, 0);
        check_val("t3_over",    game_over,     1);
        check_val("t3_size",    size,          5);
        check_val("t3_respawn", apple_respawn, 0);
        for (int k = 1; k <= 3 * TDIV; k++) begin
            tick(0, 1, 0, 0, 0, 0);
            check_val("t3_no_update", update, 0);
            check_val("t3_start_held", start, 1);
        end
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        check_val("t3_home_start", start,     0);
        check_val("t3_home_over",  game_over, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        check_val("t3_restart_start", start, 1);
        check_val("t3_restart_size",  size,  3);
        check_val("t3_restart_score", score, 0);

        $display("txn: size saturation");
        for (int i = 0; i < 30; i++) apple_frame();
        check_val("t4_size",  size,  31);
        check_val("t4_score", score, 30);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        check_val("t4_norestart_size",  size,      31);
        check_val("t4_norestart_score", score,     30);
        check_val("t4_norestart_over",  game_over, 0);

        $display("txn: reset mid-run with frame_end and apple");
        tick(1, 1, 1, 1, 0, 0);
        check_reset_values("t5");

`ifdef SNAKE_SPEEDUP_EN
        $display("txn: speedup periods");
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        measure_period("t6_period_size3", 40);
        for (int i = 0; i < 5; i++) apple_frame();
        check_val("t6_size8", size, 8);
        measure_period("t6_period_size8", 20);
        for (int i = 0; i < 23; i++) apple_frame();
        check_val("t6_size31", size, 31);
        measure_period("t6_period_floor", 8);
`endif

        $display("txn: random traffic");
        btn = 0;
        for (int i = 0; i < 600; i++) begin
            bit r, b;
            r = ($urandom_range(0, 299) == 0);
            b = ($urandom_range(0, 14) == 0) ? ~btn : btn;
            tick(r, b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
